// File: rtl/lcd8080_pkg.sv
// Shared command codes, idle pin levels and byte-merge helper for the 8080 responder.
package lcd8080_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;
   localparam logic [7:0] CMD_RDID  = 8'h04;

   localparam logic        IDLE_CS   = 1'b1;
   localparam logic        IDLE_RS   = 1'b0;
   localparam logic        IDLE_WR   = 1'b1;
   localparam logic        IDLE_RD   = 1'b1;
   localparam logic [15:0] IDLE_DATA = 16'h0000;

   // Window parameters arrive as high byte then low byte of a 16-bit value.
   function automatic logic [15:0] put_byte(input logic [15:0] old, input logic hi,
                                            input logic [7:0] b);
      return hi ? {b, old[7:0]} : {old[15:8], b};
   endfunction

endpackage

// File: rtl/lcd8080_pix_fifo.sv
// Synchronous first-word-fall-through FIFO holding addressed pixels.
module lcd8080_pix_fifo
   import lcd8080_pkg::*;
#(
   parameter int W     = 34,
   parameter int DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_LVL = DEPTH[AW:0];

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;
   logic         w_push_ok;
   logic         w_pop_ok;

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push_ok) r_wp <= r_wp + 1'b1;
         if (w_pop_ok)  r_rp <= r_rp + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wp[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rp[AW-1:0]];
   assign o_level = r_wp - r_rp;
   assign o_empty = (o_level == '0);
   assign o_full  = (o_level == FULL_LVL);

endmodule

// File: rtl/lcd8080_responder.sv
// Display-side 8080 bus responder: command/window decode, RAMWR pixel stream, optional reads.
// Read drive is built only when LCD8080_RESPONDER_READ_EN is defined.
module lcd8080_responder
   import lcd8080_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter int          XW          = 9,
   parameter int          YW          = 9,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEV_ID      = 16'h8080
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          CS_8080,
   input  logic          RS_8080,
   input  logic          WR_8080,
   input  logic          RD_8080,
   inout  wire  [15:0]   DATA_8080,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic [15:0]   pix_data,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          ovf,
   input  logic          ovf_clr,
   output logic [7:0]    cur_cmd
);

   localparam int            LW        = $clog2(FIFO_DEPTH) + 1;
   localparam int            PW        = 16 + XW + YW;
   localparam logic [19:0]   SYNC_IDLE = {IDLE_CS, IDLE_RS, IDLE_WR, IDLE_RD, IDLE_DATA};

   logic [19:0]   r_sync [SYNC_STAGES];
   logic          r_p_wr;
   logic [7:0]    r_cur_cmd;
   logic [2:0]    r_param_idx;
   logic [XW-1:0] r_xs, r_xe, r_x;
   logic [YW-1:0] r_ys, r_ye, r_y;
   logic          r_ovf;

   logic          w_s_cs, w_s_rs, w_s_wr, w_s_rd;
   logic [15:0]   w_s_data;
   logic          w_wr_evt, w_cmd_wr, w_dat_wr, w_push, w_pop, w_drop;
   logic          w_param_ld, w_hi, w_end;
   logic          w_full, w_empty;
   logic [LW-1:0] w_level;

   // All strobes and data share one delay line so they stay cycle-aligned.
   assign {w_s_cs, w_s_rs, w_s_wr, w_s_rd, w_s_data} = r_sync[SYNC_STAGES-1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_IDLE;
         r_p_wr <= IDLE_WR;
      end else begin
         r_sync[0] <= {CS_8080, RS_8080, WR_8080, RD_8080, DATA_8080};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_p_wr <= w_s_wr;
      end
   end

   assign w_wr_evt   = ~r_p_wr & w_s_wr & ~w_s_cs;
   assign w_cmd_wr   = w_wr_evt & ~w_s_rs;
   assign w_dat_wr   = w_wr_evt & w_s_rs;
   assign w_push     = w_dat_wr & (r_cur_cmd == CMD_RAMWR);
   assign w_pop      = pix_valid & pix_ready;
   assign w_drop     = w_push & w_full & ~w_pop;
   assign w_param_ld = w_dat_wr & ~r_param_idx[2] &
                       ((r_cur_cmd == CMD_CASET) | (r_cur_cmd == CMD_PASET));
   assign w_hi       = ~r_param_idx[0];
   assign w_end      = r_param_idx[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cur_cmd   <= '0;
         r_param_idx <= '0;
         r_xs        <= '0;
         r_xe        <= '1;
         r_ys        <= '0;
         r_ye        <= '1;
         r_x         <= '0;
         r_y         <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_cmd_wr) begin
            r_cur_cmd   <= w_s_data[7:0];
            r_param_idx <= '0;
            if (w_s_data[7:0] == CMD_RAMWR) begin
               r_x <= r_xs;
               r_y <= r_ys;
            end
         end
         // Index stops at 4, so writes past the fourth parameter byte are ignored.
         if (w_param_ld) begin
            r_param_idx <= r_param_idx + 3'd1;
            if (r_cur_cmd == CMD_CASET) begin
               if (w_end) r_xe <= XW'(put_byte(16'(r_xe), w_hi, w_s_data[7:0]));
               else       r_xs <= XW'(put_byte(16'(r_xs), w_hi, w_s_data[7:0]));
            end else begin
               if (w_end) r_ye <= YW'(put_byte(16'(r_ye), w_hi, w_s_data[7:0]));
               else       r_ys <= YW'(put_byte(16'(r_ys), w_hi, w_s_data[7:0]));
            end
         end
         // Coordinates advance even when the pixel itself is dropped.
         if (w_push) begin
            if (r_x == r_xe) begin
               r_x <= r_xs;
               r_y <= (r_y == r_ye) ? r_ys : r_y + YW'(1);
            end else begin
               r_x <= r_x + XW'(1);
            end
         end
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   lcd8080_pix_fifo #(
      .W     (PW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (HCLK),
      .i_rst_n (HRESETn),
      .i_push  (w_push),
      .i_data  ({w_s_data, r_x, r_y}),
      .i_pop   (w_pop),
      .o_data  ({pix_data, pix_x, pix_y}),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign pix_valid = ~w_empty;
   assign ovf       = r_ovf;
   assign cur_cmd   = r_cur_cmd;

`ifdef LCD8080_RESPONDER_READ_EN
   logic        r_p_rd;
   logic [15:0] r_rd_val;
   logic        w_rd_oe;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_p_rd   <= IDLE_RD;
         r_rd_val <= '0;
      end else begin
         r_p_rd <= w_s_rd;
         if (r_p_rd & ~w_s_rd & ~w_s_cs)
            r_rd_val <= (r_cur_cmd == CMD_RDID) ? DEV_ID : {r_ovf, 3'b000, 12'(w_level)};
      end
   end

   // Enable is combinational on the synchronised strobes so reset releases the bus at once.
   assign w_rd_oe   = ~w_s_cs & ~w_s_rd;
   assign DATA_8080 = w_rd_oe ? r_rd_val : 16'hzzzz;
`else
   logic w_unused;
   assign w_unused = ^{DEV_ID, w_s_rd, w_level};
`endif

endmodule

// File: tb/tb_lcd8080_responder.sv
// Randomised scoreboard bench for lcd8080_responder with a coordinate-index reference model.
module tb_lcd8080_responder;

   localparam int SYNC  = 2;
   localparam int XW    = 9;
   localparam int YW    = 9;
   localparam int DEPTH = 8;
   localparam int XM    = 1 << XW;
   localparam int YM    = 1 << YW;
   localparam int PW    = 16 + XW + YW;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          CS_8080 = 1'b1;
   logic          RS_8080 = 1'b0;
   logic          WR_8080 = 1'b1;
   logic          RD_8080 = 1'b1;
   logic          pix_ready = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          pix_valid, ovf;
   logic [15:0]   pix_data;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [7:0]    cur_cmd;
   wire  [15:0]   DATA_8080;
   logic          tb_oe = 1'b0;
   logic [15:0]   tb_dat = 16'h0;

   assign DATA_8080 = tb_oe ? tb_dat : 16'hzzzz;
   always #5 HCLK = ~HCLK;

   lcd8080_responder #(
      .SYNC_STAGES (SYNC), .XW (XW), .YW (YW), .FIFO_DEPTH (DEPTH), .DEV_ID (16'h8080)
   ) dut (
      .HCLK (HCLK), .HRESETn (HRESETn), .CS_8080 (CS_8080), .RS_8080 (RS_8080),
      .WR_8080 (WR_8080), .RD_8080 (RD_8080), .DATA_8080 (DATA_8080),
      .pix_valid (pix_valid), .pix_ready (pix_ready), .pix_data (pix_data),
      .pix_x (pix_x), .pix_y (pix_y), .ovf (ovf), .ovf_clr (ovf_clr), .cur_cmd (cur_cmd)
   );

   int            n_tot = 0;
   int            n_bad = 0;
   logic [PW-1:0] exp_q [$];
   logic          rnd_mode = 1'b0;
   logic          rdy_force = 1'b0;

   // Reference model state: window, current command, parameter index, pixel index since RAMWR.
   int   m_cmd, m_idx, m_xs, m_xe, m_ys, m_ye, m_k;
   logic m_ovf;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_tot++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic logic bus_rel();
      return $isunknown(DATA_8080) || (DATA_8080 == 16'h0000);
   endfunction

   function automatic int set_b(input int old, input bit hi, input int b, input int md);
      return hi ? (b * 256 + old % 256) % md : ((old / 256) * 256 + b) % md;
   endfunction

   task automatic m_reset();
      m_cmd = 0; m_idx = 0; m_k = 0; m_ovf = 1'b0;
      m_xs = 0; m_xe = XM - 1; m_ys = 0; m_ye = YM - 1;
      exp_q.delete();
   endtask

   task automatic m_write(input logic rs, input logic [15:0] d);
      int b, w, h, px, py;
      b = int'(d[7:0]);
      if (!rs) begin
         m_cmd = b; m_idx = 0;
         if (b == 'h2C) m_k = 0;
      end else if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_idx < 4) begin
         if (m_cmd == 'h2A) begin
            if (m_idx < 2) m_xs = set_b(m_xs, m_idx == 0, b, XM);
            else           m_xe = set_b(m_xe, m_idx == 2, b, XM);
         end else begin
            if (m_idx < 2) m_ys = set_b(m_ys, m_idx == 0, b, YM);
            else           m_ye = set_b(m_ye, m_idx == 2, b, YM);
         end
         m_idx++;
      end else if (m_cmd == 'h2C) begin
         w  = (m_xe - m_xs + XM) % XM + 1;
         h  = (m_ye - m_ys + YM) % YM + 1;
         px = (m_xs + m_k % w) % XM;
         py = (m_ys + (m_k / w) % h) % YM;
         if (exp_q.size() < DEPTH) exp_q.push_back({d, XW'(px), YW'(py)});
         else                      m_ovf = 1'b1;
         m_k++;
      end
   endtask

   // Bus write; the responder acts SYNC+1 edges after WR rises, where the model is updated.
   task automatic wr(input logic rs, input logic [15:0] d, input logic cs = 1'b0,
                     input logic pulse = 1'b0);
      @(posedge HCLK); #1;
      CS_8080 = cs; RS_8080 = rs; tb_dat = d; tb_oe = 1'b1; WR_8080 = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 WR_8080 = 1'b1;
      repeat (2) @(posedge HCLK);
      #1 if (pulse) rdy_force = 1'b1;
      @(posedge HCLK);
      #1 if (pulse) rdy_force = 1'b0;
      if (!cs) begin
         m_write(rs, d);
         if (!rs) chk("cur_cmd", cur_cmd, d[7:0]);
      end
      repeat (2) @(posedge HCLK);
      #1 CS_8080 = 1'b1; tb_oe = 1'b0;
   endtask

   task automatic rd(input logic cs, input logic [15:0] want);
      @(posedge HCLK); #1;
      CS_8080 = cs; RD_8080 = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge HCLK); @(negedge HCLK);
         if (c >= SYNC + 2) begin
`ifdef LCD8080_RESPONDER_READ_EN
            if (!cs) chk("rd_data", DATA_8080, want);
            else     chk("rd_cs_float", bus_rel(), 1'b1);
`else
            chk("rd_float", bus_rel(), 1'b1);
`endif
         end
      end
      @(posedge HCLK); #1 RD_8080 = 1'b1;
      repeat (SYNC + 1) @(posedge HCLK);
      @(negedge HCLK);
      chk("rd_release", bus_rel(), 1'b1);
      CS_8080 = 1'b1;
   endtask

   task automatic set_window(input int xs, input int xe, input int ys, input int ye,
                             input bit extra);
      wr(1'b0, 16'h002A);
      wr(1'b1, {8'($urandom), 8'(xs >> 8)}); wr(1'b1, {8'($urandom), 8'(xs)});
      wr(1'b1, {8'($urandom), 8'(xe >> 8)}); wr(1'b1, {8'($urandom), 8'(xe)});
      if (extra) wr(1'b1, 16'($urandom));
      wr(1'b0, 16'h002B);
      wr(1'b1, {8'($urandom), 8'(ys >> 8)}); wr(1'b1, {8'($urandom), 8'(ys)});
      wr(1'b1, {8'($urandom), 8'(ye >> 8)}); wr(1'b1, {8'($urandom), 8'(ye)});
      if (extra) wr(1'b1, 16'($urandom));
   endtask

   task automatic drain();
      rnd_mode = 1'b0; rdy_force = 1'b1;
      for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(posedge HCLK);
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_valid", pix_valid, 1'b0);
      #1 rdy_force = 1'b0;
   endtask

   initial forever begin
      @(posedge HCLK); #2;
      pix_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_force;
   end

   initial begin : monitor
      logic [PW-1:0] e;
      forever begin
         @(negedge HCLK);
         if (HRESETn && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               n_tot++; n_bad++;
               $display("FAIL pix_unexpected: got %h expected none", {pix_data, pix_x, pix_y});
            end else begin
               e = exp_q.pop_front();
               chk("pix", {pix_data, pix_x, pix_y}, e);
            end
         end
      end
   end

   initial begin : stim
      int xs, ys, n;
      m_reset();
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_valid", pix_valid, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_cmd", cur_cmd, 8'h00);
      chk("rst_bus", bus_rel(), 1'b1);
      @(posedge HCLK); #1 HRESETn = 1'b1;

      // Fixed window 2..3 x 5..6, six pixels streamed out.
      rdy_force = 1'b1;
      set_window(2, 3, 5, 6, 1'b0);
      wr(1'b0, 16'h002C);
      for (int i = 0; i < 6; i++) wr(1'b1, 16'hF800 + 16'(i));
      drain();

      // Backpressure with overflow, then clear and drain.
      wr(1'b0, 16'h002C);
      for (int i = 0; i < 10; i++) begin
         wr(1'b1, 16'(16'hA000 + i));
         if (i == 0) chk("valid_after_first", pix_valid, 1'b1);
      end
      chk("ovf_set", ovf, m_ovf);
      rd(1'b0, {m_ovf, 3'b000, 12'(exp_q.size())});
      @(posedge HCLK); #1 ovf_clr = 1'b1;
      @(posedge HCLK); #1 ovf_clr = 1'b0; m_ovf = 1'b0;
      chk("ovf_clr", ovf, 1'b0);
      drain();

      // Full FIFO with a pop in the push cycle: the push is kept.
      wr(1'b0, 16'h002C);
      for (int i = 0; i < DEPTH; i++) wr(1'b1, 16'(16'h5500 + i));
      wr(1'b1, 16'h55FF, 1'b0, 1'b1);
      chk("ovf_full_pop", ovf, 1'b0);
      chk("level_full_pop", exp_q.size(), DEPTH);
      drain();

      // Status read with three queued pixels, then device ID read.
      wr(1'b0, 16'h002C);
      for (int i = 0; i < 3; i++) wr(1'b1, 16'(16'h3300 + i));
      wr(1'b0, 16'h0000);
      rd(1'b0, {m_ovf, 3'b000, 12'(exp_q.size())});
      drain();
      wr(1'b0, 16'h0004);
      rd(1'b0, 16'h8080);

      // Chip select high: writes and reads have no effect.
      wr(1'b0, 16'h002C, 1'b1);
      wr(1'b1, 16'h1234, 1'b1);
      wr(1'b1, 16'h5678, 1'b1);
      @(negedge HCLK);
      chk("cs_cmd_kept", cur_cmd, 8'(m_cmd));
      chk("cs_no_push", pix_valid, 1'b0);
      rd(1'b1, 16'h0000);

      // Random windows (some wrapping past 2^XW) with random consumer stalls.
      for (int w = 0; w < 4; w++) begin
         xs = $urandom_range(0, XM - 1);
         ys = $urandom_range(0, YM - 1);
         set_window(xs, (xs + $urandom_range(0, 3)) % XM,
                    ys, (ys + $urandom_range(0, 2)) % YM, w[0]);
         wr(1'b1, 16'($urandom));
         wr(1'b0, 16'h002C);
         rnd_mode = w[1]; rdy_force = 1'b1;
         n = $urandom_range(6, 14);
         for (int i = 0; i < n; i++) begin
            for (int t = 0; t < 500 && exp_q.size() >= DEPTH; t++) @(posedge HCLK);
            chk("space_wait", exp_q.size() < DEPTH, 1'b1);
            wr(1'b1, 16'($urandom));
         end
         drain();
      end

      // Reset while a read is driving with a full, overflowed FIFO.
      wr(1'b0, 16'h002C);
      for (int i = 0; i < DEPTH + 2; i++) wr(1'b1, 16'(16'h7700 + i));
      @(posedge HCLK); #1;
      CS_8080 = 1'b0; RD_8080 = 1'b0;
      repeat (SYNC + 3) @(posedge HCLK);
      @(negedge HCLK);
`ifdef LCD8080_RESPONDER_READ_EN
      chk("pre_rst_drive", DATA_8080, {m_ovf, 3'b000, 12'(exp_q.size())});
`else
      chk("pre_rst_float", bus_rel(), 1'b1);
`endif
      chk("pre_rst_ovf", ovf, 1'b1);
      #1 HRESETn = 1'b0;
      #1;
      chk("mid_rst_bus", bus_rel(), 1'b1);
      chk("mid_rst_valid", pix_valid, 1'b0);
      chk("mid_rst_ovf", ovf, 1'b0);
      chk("mid_rst_cmd", cur_cmd, 8'h00);
      m_reset();
      RD_8080 = 1'b1; CS_8080 = 1'b1;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // Default window after reset starts at the origin.
      rdy_force = 1'b1;
      wr(1'b0, 16'h002C);
      wr(1'b1, 16'hBEEF);
      wr(1'b1, 16'hCAFE);
      drain();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
